// File: rtl/coax_tx_frame_loader.sv
// Packs a big-endian host byte stream into 10-bit coax words, writes them into the
// transmit buffer and sequences the start/completion handshake with the transmitter.
module coax_tx_frame_loader #(
  parameter int MAX_WORDS     = 1024,
  parameter int READY_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_strobe,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic [9:0] tx_data,
  output logic       tx_load_strobe,
  output logic       tx_start_strobe,
  input  logic       tx_full,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] error,
  output logic [10:0] word_count
);

  localparam int              TO_W   = $clog2(READY_TIMEOUT + 1);
  localparam logic [10:0]     MAX_WC = 11'(MAX_WORDS);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(READY_TIMEOUT);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ODD  = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    S_HIGH,
    S_LOW,
    S_LOAD,
    S_DISCARD,
    S_START,
    S_WAIT_FALL,
    S_WAIT_RISE
  } state_t;

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic [10:0]     wc_q, wc_d;
  logic            load_q, load_d;
  logic            start_q, start_d;
  logic [9:0]      tx_data_q, tx_data_d;
  logic [1:0]      hi_q, hi_d;
  logic            last_q, last_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            accept;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v >= MAX_WC) ? MAX_WC : v + 11'd1;
  endfunction

  assign accept = byte_strobe && ready_q;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    wc_d      = wc_q;
    load_d    = 1'b0;
    start_d   = 1'b0;
    tx_data_d = tx_data_q;
    hi_d      = hi_q;
    last_d    = last_q;
    to_d      = to_q;

    case (state_q)
      S_HIGH: begin
        if (accept) begin
          // First byte of a new frame wipes the previous frame's status.
          if (!busy_q) begin
            busy_d = 1'b1;
            err_d  = ERR_NONE;
            wc_d   = '0;
          end
          if (byte_last) begin
            err_d = ERR_ODD;
            if (busy_q && (wc_q != '0)) begin
              state_d = S_START;
            end else begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end
          end else begin
            hi_d    = byte_data[1:0];
            state_d = S_LOW;
          end
        end
      end

      S_LOW: begin
        if (accept) begin
          tx_data_d = {hi_q, byte_data};
          last_d    = byte_last;
          if (wc_q == MAX_WC) begin
            err_d   = ERR_OVF;
            state_d = byte_last ? S_START : S_DISCARD;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (!tx_full) begin
          load_d  = 1'b1;
          wc_d    = sat_inc(wc_q);
          state_d = last_q ? S_START : S_HIGH;
        end
      end

      S_DISCARD: begin
        if (accept && byte_last) begin
          state_d = S_START;
        end
      end

      S_START: begin
        start_d = 1'b1;
        to_d    = '0;
        state_d = S_WAIT_FALL;
      end

      S_WAIT_FALL: begin
        if (!tx_ready) begin
          state_d = S_WAIT_RISE;
        end else if (to_q == TO_LIM) begin
          err_d   = ERR_TMO;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_HIGH;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_WAIT_RISE: begin
        if (tx_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_HIGH;
        end
      end

      default: state_d = S_HIGH;
    endcase

    ready_d = (state_d == S_HIGH) || (state_d == S_LOW) || (state_d == S_DISCARD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HIGH;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_NONE;
      wc_q      <= '0;
      load_q    <= 1'b0;
      start_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wc_q      <= wc_d;
      load_q    <= load_d;
      start_q   <= start_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Staging registers are always written before they are consumed, so no reset.
  always_ff @(posedge clk) begin
    hi_q   <= hi_d;
    last_q <= last_d;
    to_q   <= to_d;
  end

  assign byte_ready      = ready_q;
  assign tx_data         = tx_data_q;
  assign tx_load_strobe  = load_q;
  assign tx_start_strobe = start_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = err_q;
  assign word_count      = wc_q;

endmodule

// File: tb/tb_coax_tx_frame_loader.sv
// Scoreboard bench: a frame-level model queues expected loads/starts/completions,
// a monitor pops and compares them whenever the loader strobes.
module tb_coax_tx_frame_loader;

  localparam int MAX_W   = 4;
  localparam int TMO     = 10;
  localparam int K_LOAD  = 0;
  localparam int K_START = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int          kind;
    logic [9:0]  data;
    logic [1:0]  err;
    logic [10:0] wc;
    int          gap;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byte_data;
  logic        byte_strobe;
  logic        byte_last;
  logic        byte_ready;
  logic [9:0]  tx_data;
  logic        tx_load_strobe;
  logic        tx_start_strobe;
  logic        tx_full;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic [1:0]  error;
  logic [10:0] word_count;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  full_mode = 0;
  int  xmit_mode = 0;
  ev_t expq[$];

  coax_tx_frame_loader #(.MAX_WORDS(MAX_W), .READY_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .byte_data(byte_data), .byte_strobe(byte_strobe), .byte_last(byte_last),
    .byte_ready(byte_ready),
    .tx_data(tx_data), .tx_load_strobe(tx_load_strobe), .tx_start_strobe(tx_start_strobe),
    .tx_full(tx_full), .tx_ready(tx_ready),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Buffer-full driver: 0 never full, 1 random, 2 held full.
  initial begin
    tx_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (full_mode)
        1:       tx_full = ($urandom_range(0, 3) == 0);
        2:       tx_full = 1'b1;
        default: tx_full = 1'b0;
      endcase
    end
  end

  // Transmitter: drops ready a few cycles after start, raises it later; mode 1 never responds.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start_strobe && xmit_mode == 0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        tx_ready = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        tx_ready = 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    ev_t e;
    int  last_load = -100;
    int  start_at  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (tx_load_strobe) begin
          chk("load_spacing", 32'((cyc - last_load) >= 3), 32'd1);
          last_load = cyc;
          chk("load_expected", 32'(expq.size() > 0), 32'd1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("load_kind", 32'(K_LOAD), 32'(e.kind));
            chk("load_data", 32'(tx_data), 32'(e.data));
          end
        end
        if (tx_start_strobe) begin
          start_at = cyc;
          chk("start_expected", 32'(expq.size() > 0), 32'd1);
          chk("start_wc_nonzero", 32'(word_count != 0), 32'd1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("start_kind", 32'(K_START), 32'(e.kind));
            if (e.gap >= 0) chk("start_after_load", 32'(cyc - last_load), 32'(e.gap));
          end
        end
        if (done) begin
          chk("done_expected", 32'(expq.size() > 0), 32'd1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("done_kind", 32'(K_DONE), 32'(e.kind));
            chk("done_error", 32'(error), 32'(e.err));
            chk("done_word_count", 32'(word_count), 32'(e.wc));
            chk("done_busy", 32'(busy), 32'd0);
            if (e.gap >= 0) chk("done_after_start", 32'(cyc - start_at), 32'(e.gap));
          end
        end
      end
    end
  end

  // Frame-level reference: pairs become words, count capped, error from length rules.
  task automatic expect_frame(input logic [7:0] b[$], input bit stuck);
    int         n;
    int         np;
    int         nw;
    logic [1:0] err;
    ev_t        e;
    n   = b.size();
    np  = n / 2;
    nw  = (np > MAX_W) ? MAX_W : np;
    err = (np > MAX_W) ? 2'd2 : ((n % 2) == 1) ? 2'd1 : 2'd0;
    for (int i = 0; i < nw; i++) begin
      e = '{kind: K_LOAD, data: {b[2*i][1:0], b[2*i+1]}, err: 2'd0, wc: 11'd0, gap: -1};
      expq.push_back(e);
    end
    if (nw > 0) begin
      e = '{kind: K_START, data: 10'd0, err: 2'd0, wc: 11'd0, gap: (err == 2'd0) ? 1 : -1};
      expq.push_back(e);
      if (stuck) err = 2'd3;
    end
    e = '{kind: K_DONE, data: 10'd0, err: err, wc: 11'(nw), gap: (stuck && nw > 0) ? TMO + 1 : -1};
    expq.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b, input logic l);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    byte_data   = b;
    byte_last   = l;
    byte_strobe = 1'b1;
    while (!acc) begin
      acc = byte_ready;
      @(negedge clk);
      n++;
      if (!acc && n > 300) begin
        $display("FAIL byte_accept_timeout: byte_ready stuck at %0d, required 1", byte_ready);
        $fatal(1, "byte never accepted");
      end
    end
    byte_strobe = 1'b0;
    byte_last   = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("frame_drained", 32'(expq.size()), 32'd0);
    expq.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b[$], input bit stuck);
    xmit_mode = stuck ? 1 : 0;
    expect_frame(b, stuck);
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(b[i], logic'(i == b.size() - 1));
    end
    wait_drain();
  endtask

  initial begin
    logic [7:0] fr[$];
    logic       hold_ok;
    int         n;
    byte_data   = 8'h00;
    byte_strobe = 1'b0;
    byte_last   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_byte_ready", 32'(byte_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_load", 32'(tx_load_strobe), 32'd0);
    chk("rst_start", 32'(tx_start_strobe), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    fr = '{8'h01, 8'h23, 8'h02, 8'h45};
    send_frame(fr, 1'b0);

    // Buffer full while the second word waits in the loader.
    fr = '{8'h02, 8'h11, 8'h03, 8'h45};
    xmit_mode = 0;
    expect_frame(fr, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    repeat (4) @(negedge clk);
    full_mode = 2;
    repeat (2) @(negedge clk);
    send_byte(8'h03, 1'b0);
    send_byte(8'h45, 1'b1);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (byte_ready !== 1'b0 || tx_load_strobe !== 1'b0 || tx_data !== 10'h345) hold_ok = 1'b0;
      @(negedge clk);
    end
    chk("full_hold_stable", 32'(hold_ok), 32'd1);
    full_mode = 0;
    @(negedge clk);
    chk("full_fall_seen", 32'(tx_full), 32'd0);
    chk("full_fall_no_strobe_yet", 32'(tx_load_strobe), 32'd0);
    @(negedge clk);
    chk("full_fall_strobe", 32'(tx_load_strobe), 32'd1);
    wait_drain();

    fr = '{8'h03, 8'hFF, 8'h01};
    send_frame(fr, 1'b0);
    fr = '{8'h5A};
    send_frame(fr, 1'b0);

    fr = '{8'h01, 8'h10, 8'h02, 8'h20, 8'h03, 8'h30, 8'h00, 8'h40,
           8'h01, 8'h50, 8'h02, 8'h60};
    send_frame(fr, 1'b0);
    fr = '{8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 8'h00, 8'h44, 8'h01, 8'h55};
    send_frame(fr, 1'b0);

    fr = '{8'h01, 8'h77, 8'h02, 8'h88};
    send_frame(fr, 1'b1);

    // Reset while parked in LOAD behind a full buffer.
    xmit_mode = 0;
    full_mode = 2;
    repeat (2) @(negedge clk);
    send_byte(8'h01, 1'b0);
    send_byte(8'h55, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_byte_ready", 32'(byte_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_load", 32'(tx_load_strobe), 32'd0);
    chk("mid_rst_start", 32'(tx_start_strobe), 32'd0);
    reset = 1'b0;
    full_mode = 0;
    @(negedge clk);
    chk("post_rst_load", 32'(tx_load_strobe), 32'd0);
    chk("post_rst_start", 32'(tx_start_strobe), 32'd0);
    fr = '{8'hFE, 8'h01, 8'h01, 8'hC3};
    send_frame(fr, 1'b0);

    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 12);
      fr = {};
      for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
      full_mode = $urandom_range(0, 1);
      send_frame(fr, $urandom_range(0, 5) == 0);
    end
    full_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, required to finish", cyc);
    $fatal(1, "global timeout");
  end

endmodule
